// File: rtl/pipelined_ctrl_unit_pkg.sv
`default_nettype none
// ============================================================================
// pipelined_ctrl_unit_pkg : RV32IM control encodings and stage-register types
// Rev 1.0
// ============================================================================
package pipelined_ctrl_unit_pkg;

    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;

    localparam logic [6:0] c_F7_BASE   = 7'b0000000;
    localparam logic [6:0] c_F7_ALT    = 7'b0100000;
    localparam logic [6:0] c_F7_MEXT   = 7'b0000001;

    localparam logic [1:0] c_SD_ALU    = 2'd0;
    localparam logic [1:0] c_SD_MEM    = 2'd1;
    localparam logic [1:0] c_SD_PC4    = 2'd2;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,  ALU_SUB    = 4'd1,  ALU_AND    = 4'd2,  ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,  ALU_SLL    = 4'd5,  ALU_SRL    = 4'd6,  ALU_SRA    = 4'd7,
        ALU_SLT    = 4'd8,  ALU_SLTU   = 4'd9,  ALU_PASSB  = 4'd10, ALU_MUL    = 4'd11,
        ALU_MULH   = 4'd12, ALU_MULHSU = 4'd13, ALU_MULHU  = 4'd14, ALU_DIVREM = 4'd15
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4
    } imm_sel_e;

    // sel_opA: 0 = rs1, 1 = PC.  sel_opB: 0 = rs2, 1 = immediate.
    typedef struct packed {
        alu_op_e  alu_op;
        logic     sel_opA;
        logic     sel_opB;
        imm_sel_e imm_select;
        logic     is_mext;
    } ex_ctrl_t;

    typedef struct packed {
        logic       is_stype;
        logic [2:0] dm_select;
        logic [1:0] store_select;
    } mem_ctrl_t;

    typedef struct packed {
        logic       wr_en;
        logic [1:0] sel_data;
    } wb_ctrl_t;

    typedef struct packed {
        logic      valid;
        logic      illegal;
        ex_ctrl_t  ex;
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
    } ctrl_t;

    typedef struct packed {
        logic      valid;
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
    } mem_stage_t;

    typedef struct packed {
        logic     valid;
        wb_ctrl_t wb;
    } wb_stage_t;

    // ALU op selected by funct3 for the base integer R/I encodings.
    function automatic alu_op_e base_alu(input logic [2:0] f3);
        alu_op_e op;
        case (f3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_ctrl_unit_if.sv
`default_nettype none
// ============================================================================
// pipelined_ctrl_unit_if : front-end/datapath handshake of the control unit
// Rev 1.0
// ============================================================================
interface pipelined_ctrl_unit_if;
    logic       id_valid;
    logic [6:0] id_opcode;
    logic [2:0] id_funct3;
    logic [6:0] id_funct7;
    logic       hz_stall;
    logic       flush_ex;

    logic       ex_valid;
    logic [3:0] ex_alu_op;
    logic       ex_sel_opA;
    logic       ex_sel_opB;
    logic [2:0] ex_imm_select;
    logic       ex_is_mext;
    logic       mem_valid;
    logic       mem_is_stype;
    logic [2:0] mem_dm_select;
    logic [1:0] mem_store_select;
    logic       wb_valid;
    logic       wb_wr_en;
    logic [1:0] wb_sel_data;
    logic       mext_busy;
    logic       illegal_instr;

    modport master (
        output id_valid, id_opcode, id_funct3, id_funct7, hz_stall, flush_ex,
        input  ex_valid, ex_alu_op, ex_sel_opA, ex_sel_opB, ex_imm_select, ex_is_mext,
        input  mem_valid, mem_is_stype, mem_dm_select, mem_store_select,
        input  wb_valid, wb_wr_en, wb_sel_data, mext_busy, illegal_instr
    );

    modport slave (
        input  id_valid, id_opcode, id_funct3, id_funct7, hz_stall, flush_ex,
        output ex_valid, ex_alu_op, ex_sel_opA, ex_sel_opB, ex_imm_select, ex_is_mext,
        output mem_valid, mem_is_stype, mem_dm_select, mem_store_select,
        output wb_valid, wb_wr_en, wb_sel_data, mext_busy, illegal_instr
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_ctrl_unit_decode.sv
`default_nettype none
// ============================================================================
// pipelined_ctrl_unit_decode : combinational RV32IM ID decode with illegal detect
// Rev 1.0
// ============================================================================
module pipelined_ctrl_unit_decode
    import pipelined_ctrl_unit_pkg::*;
#(
    parameter int EN_MEXT = 1
) (
    input  logic       i_valid,
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_funct7,
    output ctrl_t      o_ctrl
);

    ctrl_t w_ctrl;
    logic  w_bad;

    always_comb begin
        w_ctrl = '0;
        w_bad  = 1'b0;
        case (i_opcode)
            c_OP_LUI: begin
                w_ctrl.ex.alu_op     = ALU_PASSB;
                w_ctrl.ex.sel_opB    = 1'b1;
                w_ctrl.ex.imm_select = IMM_U;
                w_ctrl.wb.wr_en      = 1'b1;
            end
            c_OP_AUIPC: begin
                w_ctrl.ex.sel_opA    = 1'b1;
                w_ctrl.ex.sel_opB    = 1'b1;
                w_ctrl.ex.imm_select = IMM_U;
                w_ctrl.wb.wr_en      = 1'b1;
            end
            c_OP_JAL: begin
                w_ctrl.ex.sel_opA    = 1'b1;
                w_ctrl.ex.sel_opB    = 1'b1;
                w_ctrl.ex.imm_select = IMM_J;
                w_ctrl.wb.wr_en      = 1'b1;
                w_ctrl.wb.sel_data   = c_SD_PC4;
            end
            c_OP_JALR: begin
                w_ctrl.ex.sel_opB    = 1'b1;
                w_ctrl.ex.imm_select = IMM_I;
                w_ctrl.wb.wr_en      = 1'b1;
                w_ctrl.wb.sel_data   = c_SD_PC4;
            end
            c_OP_BRANCH: begin
                w_ctrl.ex.alu_op     = ALU_SUB;
                w_ctrl.ex.imm_select = IMM_B;
                w_bad = (i_funct3 == 3'b010) || (i_funct3 == 3'b011);
            end
            c_OP_LOAD: begin
                w_ctrl.ex.sel_opB     = 1'b1;
                w_ctrl.ex.imm_select  = IMM_I;
                w_ctrl.mem.dm_select  = i_funct3;
                w_ctrl.wb.wr_en       = 1'b1;
                w_ctrl.wb.sel_data    = c_SD_MEM;
                w_bad = i_funct3 inside {3'b011, 3'b110, 3'b111};
            end
            c_OP_STORE: begin
                w_ctrl.ex.sel_opB       = 1'b1;
                w_ctrl.ex.imm_select    = IMM_S;
                w_ctrl.mem.is_stype     = 1'b1;
                w_ctrl.mem.store_select = i_funct3[1:0];
                w_bad = (i_funct3 >= 3'b011);
            end
            c_OP_IMM: begin
                w_ctrl.ex.alu_op     = base_alu(i_funct3);
                w_ctrl.ex.sel_opB    = 1'b1;
                w_ctrl.ex.imm_select = IMM_I;
                w_ctrl.wb.wr_en      = 1'b1;
                // funct7 only qualifies the shift-immediate forms
                if (i_funct3 == 3'b001) begin
                    w_bad = (i_funct7 != c_F7_BASE);
                end else if (i_funct3 == 3'b101) begin
                    if (i_funct7 == c_F7_ALT) w_ctrl.ex.alu_op = ALU_SRA;
                    else                      w_bad = (i_funct7 != c_F7_BASE);
                end
            end
            c_OP_REG: begin
                w_ctrl.wb.wr_en = 1'b1;
                case (i_funct7)
                    c_F7_BASE: w_ctrl.ex.alu_op = base_alu(i_funct3);
                    c_F7_ALT: begin
                        if (i_funct3 == 3'b000)      w_ctrl.ex.alu_op = ALU_SUB;
                        else if (i_funct3 == 3'b101) w_ctrl.ex.alu_op = ALU_SRA;
                        else                         w_bad = 1'b1;
                    end
                    c_F7_MEXT: begin
                        if (EN_MEXT != 0) begin
                            w_ctrl.ex.is_mext = 1'b1;
                            case (i_funct3)
                                3'b000:  w_ctrl.ex.alu_op = ALU_MUL;
                                3'b001:  w_ctrl.ex.alu_op = ALU_MULH;
                                3'b010:  w_ctrl.ex.alu_op = ALU_MULHSU;
                                3'b011:  w_ctrl.ex.alu_op = ALU_MULHU;
                                default: w_ctrl.ex.alu_op = ALU_DIVREM;
                            endcase
                        end else begin
                            w_bad = 1'b1;
                        end
                    end
                    default: w_bad = 1'b1;
                endcase
            end
            default: w_bad = 1'b1;
        endcase

        if (w_bad) begin
            w_ctrl         = '0;
            w_ctrl.illegal = 1'b1;
        end
        w_ctrl.valid = 1'b1;
        if (!i_valid) w_ctrl = '0;
    end

    assign o_ctrl = w_ctrl;

endmodule
`default_nettype wire

// File: rtl/pipelined_ctrl_unit.sv
`default_nettype none
// ============================================================================
// pipelined_ctrl_unit : RV32IM control path with ID/EX, EX/MEM, MEM/WB registers,
//                       stall/flush handling and multi-cycle M-extension occupancy
// Rev 1.0
// ============================================================================
module pipelined_ctrl_unit
    import pipelined_ctrl_unit_pkg::*;
#(
    parameter int MUL_CYCLES = 1,
    parameter int DIV_CYCLES = 8,
    parameter int EN_MEXT    = 1
) (
    input  logic                 clk,
    input  logic                 nrst,
    pipelined_ctrl_unit_if.slave bus
);

    localparam logic [3:0] c_MUL_LOAD = 4'(MUL_CYCLES - 1);
    localparam logic [3:0] c_DIV_LOAD = 4'(DIV_CYCLES - 1);

    ctrl_t      w_dec;
    ctrl_t      r_ex;
    mem_stage_t r_mem;
    wb_stage_t  r_wb;
    logic [3:0] r_cnt;
    logic       w_busy;

    pipelined_ctrl_unit_decode #(
        .EN_MEXT (EN_MEXT)
    ) u_decode (
        .i_valid  (bus.id_valid),
        .i_opcode (bus.id_opcode),
        .i_funct3 (bus.id_funct3),
        .i_funct7 (bus.id_funct7),
        .o_ctrl   (w_dec)
    );

    assign w_busy = (r_cnt != 4'd0);

    // ID/EX and occupancy counter: flush beats the M-op hold, which beats hz_stall
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_ex  <= '0;
            r_cnt <= 4'd0;
        end else if (bus.flush_ex) begin
            r_ex  <= '0;
            r_cnt <= 4'd0;
        end else if (w_busy) begin
            r_cnt <= r_cnt - 4'd1;
        end else if (!bus.hz_stall) begin
            r_ex <= w_dec;
            if (w_dec.valid && w_dec.ex.is_mext) begin
                r_cnt <= (w_dec.ex.alu_op == ALU_DIVREM) ? c_DIV_LOAD : c_MUL_LOAD;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_mem <= '0;
            r_wb  <= '0;
        end else begin
            if (w_busy || bus.hz_stall) begin
                r_mem <= '0;
            end else begin
                r_mem.valid <= r_ex.valid;
                r_mem.mem   <= r_ex.mem;
                r_mem.wb    <= r_ex.wb;
            end
            r_wb.valid <= r_mem.valid;
            r_wb.wb    <= r_mem.wb;
        end
    end

    assign bus.ex_valid         = r_ex.valid;
    assign bus.ex_alu_op        = r_ex.ex.alu_op;
    assign bus.ex_sel_opA       = r_ex.ex.sel_opA;
    assign bus.ex_sel_opB       = r_ex.ex.sel_opB;
    assign bus.ex_imm_select    = r_ex.ex.imm_select;
    assign bus.ex_is_mext       = r_ex.ex.is_mext;
    assign bus.illegal_instr    = r_ex.illegal;
    assign bus.mem_valid        = r_mem.valid;
    assign bus.mem_is_stype     = r_mem.mem.is_stype;
    assign bus.mem_dm_select    = r_mem.mem.dm_select;
    assign bus.mem_store_select = r_mem.mem.store_select;
    assign bus.wb_valid         = r_wb.valid;
    assign bus.wb_wr_en         = r_wb.wb.wr_en;
    assign bus.wb_sel_data      = r_wb.wb.sel_data;
    assign bus.mext_busy        = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_ctrl_unit.sv
`default_nettype none
// ============================================================================
// tb_pipelined_ctrl_unit : directed decode table plus stall/flush/reset sequences
// Rev 1.0
// ============================================================================
module tb_pipelined_ctrl_unit;

    logic clk  = 1'b0;
    logic nrst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    pipelined_ctrl_unit_if bus ();

    pipelined_ctrl_unit #(
        .MUL_CYCLES (1),
        .DIV_CYCLES (8),
        .EN_MEXT    (1)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    typedef struct {
        string      name;
        logic       v;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [3:0] alu;
        logic       opa, opb;
        logic [2:0] imm;
        logic       mx, ill, st;
        logic [2:0] dm;
        logic [1:0] ss;
        logic       wr;
        logic [1:0] sd;
    } vec_t;

    vec_t tv [27];

    function automatic vec_t mk(string n, logic v, logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                                logic [3:0] alu, logic opa, logic opb, logic [2:0] imm, logic mx,
                                logic ill, logic st, logic [2:0] dm, logic [1:0] ss, logic wr,
                                logic [1:0] sd);
        vec_t t;
        t.name = n; t.v = v; t.op = op; t.f3 = f3; t.f7 = f7; t.alu = alu; t.opa = opa;
        t.opb = opb; t.imm = imm; t.mx = mx; t.ill = ill; t.st = st; t.dm = dm; t.ss = ss;
        t.wr = wr; t.sd = sd;
        return t;
    endfunction

    function automatic vec_t ill(string n, logic [6:0] op, logic [2:0] f3, logic [6:0] f7);
        return mk(n, 1, op, f3, f7, 4'd0, 0, 0, 3'd0, 0, 1, 0, 3'd0, 2'd0, 0, 2'd0);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7);
        bus.id_valid  = v;
        bus.id_opcode = op;
        bus.id_funct3 = f3;
        bus.id_funct7 = f7;
    endtask

    task automatic idle;
        drive(1'b0, 7'd0, 3'd0, 7'd0);
    endtask

    function automatic logic [31:0] all_outs();
        return {8'd0, bus.ex_valid, bus.ex_alu_op, bus.ex_sel_opA, bus.ex_sel_opB,
                bus.ex_imm_select, bus.ex_is_mext, bus.mem_valid, bus.mem_is_stype,
                bus.mem_dm_select, bus.mem_store_select, bus.wb_valid, bus.wb_wr_en,
                bus.wb_sel_data, bus.mext_busy, bus.illegal_instr};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nbusy, nbub, arrive, nside;

        tv[0]  = mk("add",      1, 7'b0110011, 3'b000, 7'b0000000, 4'd0,  0,0,3'd0,0,0,0,3'd0,2'd0,1,2'd0);
        tv[1]  = mk("sub",      1, 7'b0110011, 3'b000, 7'b0100000, 4'd1,  0,0,3'd0,0,0,0,3'd0,2'd0,1,2'd0);
        tv[2]  = mk("sra",      1, 7'b0110011, 3'b101, 7'b0100000, 4'd7,  0,0,3'd0,0,0,0,3'd0,2'd0,1,2'd0);
        tv[3]  = mk("sltu",     1, 7'b0110011, 3'b011, 7'b0000000, 4'd9,  0,0,3'd0,0,0,0,3'd0,2'd0,1,2'd0);
        tv[4]  = mk("or",       1, 7'b0110011, 3'b110, 7'b0000000, 4'd3,  0,0,3'd0,0,0,0,3'd0,2'd0,1,2'd0);
        tv[5]  = ill("r_badf7",    7'b0110011, 3'b000, 7'b0000010);
        tv[6]  = ill("r_alt_sll",  7'b0110011, 3'b001, 7'b0100000);
        tv[7]  = mk("srai",     1, 7'b0010011, 3'b101, 7'b0100000, 4'd7,  0,1,3'd0,0,0,0,3'd0,2'd0,1,2'd0);
        tv[8]  = ill("slli_bad",   7'b0010011, 3'b001, 7'b0100000);
        tv[9]  = mk("andi",     1, 7'b0010011, 3'b111, 7'b1010101, 4'd2,  0,1,3'd0,0,0,0,3'd0,2'd0,1,2'd0);
        tv[10] = mk("lui",      1, 7'b0110111, 3'b101, 7'b1111111, 4'd10, 0,1,3'd3,0,0,0,3'd0,2'd0,1,2'd0);
        tv[11] = mk("auipc",    1, 7'b0010111, 3'b000, 7'b0000000, 4'd0,  1,1,3'd3,0,0,0,3'd0,2'd0,1,2'd0);
        tv[12] = mk("jal",      1, 7'b1101111, 3'b000, 7'b0000000, 4'd0,  1,1,3'd4,0,0,0,3'd0,2'd0,1,2'd2);
        tv[13] = mk("jalr",     1, 7'b1100111, 3'b000, 7'b0000000, 4'd0,  0,1,3'd0,0,0,0,3'd0,2'd0,1,2'd2);
        tv[14] = mk("beq",      1, 7'b1100011, 3'b000, 7'b0000000, 4'd1,  0,0,3'd2,0,0,0,3'd0,2'd0,0,2'd0);
        tv[15] = mk("bgeu",     1, 7'b1100011, 3'b111, 7'b0000000, 4'd1,  0,0,3'd2,0,0,0,3'd0,2'd0,0,2'd0);
        tv[16] = ill("br_f3_010",  7'b1100011, 3'b010, 7'b0000000);
        tv[17] = mk("lw",       1, 7'b0000011, 3'b010, 7'b0000000, 4'd0,  0,1,3'd0,0,0,0,3'd2,2'd0,1,2'd1);
        tv[18] = mk("lbu",      1, 7'b0000011, 3'b100, 7'b0000000, 4'd0,  0,1,3'd0,0,0,0,3'd4,2'd0,1,2'd1);
        tv[19] = ill("ld_f3_110",  7'b0000011, 3'b110, 7'b0000000);
        tv[20] = mk("sw",       1, 7'b0100011, 3'b010, 7'b0000000, 4'd0,  0,1,3'd1,0,0,1,3'd0,2'd2,0,2'd0);
        tv[21] = mk("sb",       1, 7'b0100011, 3'b000, 7'b0000000, 4'd0,  0,1,3'd1,0,0,1,3'd0,2'd0,0,2'd0);
        tv[22] = ill("st_f3_011",  7'b0100011, 3'b011, 7'b0000000);
        tv[23] = ill("op_zero",    7'b0000000, 3'b000, 7'b0000000);
        tv[24] = mk("mul",      1, 7'b0110011, 3'b000, 7'b0000001, 4'd11, 0,0,3'd0,1,0,0,3'd0,2'd0,1,2'd0);
        tv[25] = mk("mulhu",    1, 7'b0110011, 3'b011, 7'b0000001, 4'd14, 0,0,3'd0,1,0,0,3'd0,2'd0,1,2'd0);
        tv[26] = mk("novalid",  0, 7'b0110011, 3'b000, 7'b0000000, 4'd0,  0,0,3'd0,0,0,0,3'd0,2'd0,0,2'd0);

        idle();
        bus.hz_stall = 1'b0;
        bus.flush_ex = 1'b0;
        #1 nrst = 1'b0;
        #2 check("reset.initial", all_outs(), 32'd0);
        step();
        step();
        nrst = 1'b1;

        // decode table: each instruction walked through EX, MEM and WB in isolation
        for (int i = 0; i < 27; i++) begin
            drive(tv[i].v, tv[i].op, tv[i].f3, tv[i].f7);
            step();
            check($sformatf("%s.ex", tv[i].name),
                  {20'd0, bus.ex_valid, bus.ex_alu_op, bus.ex_sel_opA, bus.ex_sel_opB,
                   bus.ex_imm_select, bus.ex_is_mext, bus.illegal_instr},
                  {20'd0, tv[i].v, tv[i].alu, tv[i].opa, tv[i].opb, tv[i].imm, tv[i].mx, tv[i].ill});
            idle();
            step();
            check($sformatf("%s.mem", tv[i].name),
                  {25'd0, bus.mem_valid, bus.mem_is_stype, bus.mem_dm_select, bus.mem_store_select},
                  {25'd0, tv[i].v, tv[i].st, tv[i].dm, tv[i].ss});
            step();
            check($sformatf("%s.wb", tv[i].name),
                  {28'd0, bus.wb_valid, bus.wb_wr_en, bus.wb_sel_data},
                  {28'd0, tv[i].v, tv[i].wr, tv[i].sd});
        end

        // ADD followed directly by SW
        drive(1, 7'b0110011, 3'b000, 7'b0000000);
        step();
        check("addsw.ex_add", {27'd0, bus.ex_valid, bus.ex_alu_op}, {27'd0, 1'b1, 4'd0});
        drive(1, 7'b0100011, 3'b010, 7'b0000000);
        step();
        check("addsw.ex_sw", {24'd0, bus.ex_alu_op, bus.ex_sel_opB, bus.ex_imm_select},
              {24'd0, 4'd0, 1'b1, 3'd1});
        idle();
        step();
        check("addsw.wb_add", {28'd0, bus.wb_valid, bus.wb_wr_en, bus.wb_sel_data}, 32'b1100);
        check("addsw.mem_sw", {28'd0, bus.mem_valid, bus.mem_is_stype, bus.mem_store_select},
              32'b1110);
        step();
        check("addsw.wb_sw", {30'd0, bus.wb_valid, bus.wb_wr_en}, 32'b10);
        step();
        step();

        // DIV occupies EX for DIV_CYCLES with ADD waiting in ID
        drive(1, 7'b0110011, 3'b100, 7'b0000001);
        step();
        check("div.enter", {26'd0, bus.ex_alu_op, bus.ex_is_mext, bus.mext_busy},
              {26'd0, 4'd15, 1'b1, 1'b1});
        drive(1, 7'b0110011, 3'b000, 7'b0000000);
        nbusy  = bus.mext_busy ? 1 : 0;
        nbub   = 0;
        arrive = 0;
        for (int k = 1; k <= 20; k++) begin
            if (arrive == 0) begin
                step();
                if (bus.mem_valid) arrive = k;
                else if (bus.ex_alu_op == 4'd15) nbub++;
                if (bus.mext_busy) nbusy++;
            end
        end
        check("div.busy_cycles", nbusy, 7);
        check("div.mem_bubbles", nbub, 7);
        check("div.mem_arrival", arrive, 8);
        check("div.add_enters", {30'd0, bus.ex_valid, bus.ex_is_mext}, 32'b10);
        idle();
        step();
        check("div.wb", {30'd0, bus.wb_valid, bus.wb_wr_en}, 32'b11);
        step();
        step();
        step();

        // DIV flushed in its third busy cycle
        drive(1, 7'b0110011, 3'b101, 7'b0000001);
        step();
        idle();
        step();
        step();
        check("flush.busy_before", {31'd0, bus.mext_busy}, 32'd1);
        bus.flush_ex = 1'b1;
        step();
        bus.flush_ex = 1'b0;
        check("flush.after", {30'd0, bus.mext_busy, bus.ex_valid}, 32'd0);
        nside = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (bus.mem_valid || bus.wb_valid || bus.mext_busy) nside++;
        end
        check("flush.no_side_effects", nside, 0);

        // illegal branch: pulse lasts exactly one cycle in EX
        drive(1, 7'b1100011, 3'b010, 7'b0000000);
        step();
        check("ill.pulse", {30'd0, bus.ex_valid, bus.illegal_instr}, 32'b11);
        idle();
        step();
        check("ill.mem", {29'd0, bus.illegal_instr, bus.mem_valid, bus.mem_is_stype}, 32'b010);
        step();
        check("ill.wb", {30'd0, bus.wb_valid, bus.wb_wr_en}, 32'b10);
        step();

        // hz_stall the cycle after LW enters EX
        drive(1, 7'b0000011, 3'b010, 7'b0000000);
        step();
        drive(1, 7'b0110011, 3'b000, 7'b0000000);
        bus.hz_stall = 1'b1;
        step();
        bus.hz_stall = 1'b0;
        check("hz.hold", {30'd0, bus.ex_sel_opB, bus.mem_valid}, 32'b10);
        step();
        idle();
        check("hz.advance", {26'd0, bus.ex_valid, bus.ex_sel_opB, bus.mem_valid,
                             bus.mem_dm_select}, {26'd0, 1'b1, 1'b0, 1'b1, 3'd2});
        check("hz.bubble_wb", {31'd0, bus.wb_valid}, 32'd0);
        step();
        check("hz.lw_wb", {28'd0, bus.wb_valid, bus.wb_wr_en, bus.wb_sel_data}, 32'b1101);
        step();
        check("hz.add_wb", {28'd0, bus.wb_valid, bus.wb_wr_en, bus.wb_sel_data}, 32'b1100);

        // asynchronous reset with ADD in every stage
        drive(1, 7'b0110011, 3'b000, 7'b0000000);
        step();
        step();
        step();
        check("rst.pre", {29'd0, bus.ex_valid, bus.mem_valid, bus.wb_valid}, 32'b111);
        #3 nrst = 1'b0;
        #1 check("rst.async", all_outs(), 32'd0);
        idle();
        step();
        nrst = 1'b1;
        step();
        check("rst.after", all_outs(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
